// File: rtl/gate_eval_pkg.sv
// Shared types for the gate evaluation scheduler: gate opcodes, gate table
// entry layout and the sequencer state encoding.
package gate_eval_pkg;

  // Field width of a wire index inside a table entry; must equal $clog2(NUM_WIRES).
  localparam int GE_WAW = 4;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOT = 2'b11
  } op_e;

  // Packed so a raw cfg_data word {op, src_a, src_b, dst} casts straight in.
  typedef struct packed {
    op_e               op;
    logic [GE_WAW-1:0] src_a;
    logic [GE_WAW-1:0] src_b;
    logic [GE_WAW-1:0] dst;
  } gate_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EVAL,
    ST_DONE
  } state_e;

endpackage

// File: rtl/gate_alu.sv
// Single 2-input logic operator shared by every gate in the table.
// NOT uses only a; b is ignored for that opcode.
module gate_alu
  import gate_eval_pkg::*;
(
  input  op_e  op,
  input  logic a,
  input  logic b,
  output logic y
);

  always_comb begin
    // NOTE: assign a default first so no path through the case leaves y unassigned (no latch).
    y = 1'b0;
    unique case (op)
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_NOT: y = ~a;
    endcase
  end

endmodule

// File: rtl/gate_eval_scheduler.sv
// Runs a programmable gate table one gate per cycle through a single gate_alu,
// storing results in a small wire register file and publishing outputs on done.
module gate_eval_scheduler
  import gate_eval_pkg::*;
#(
  parameter  int NUM_WIRES = 16,
  parameter  int NUM_GATES = 8,
  parameter  int NUM_IN    = 2,
  parameter  int NUM_OUT   = 2,
  localparam int WAW       = $clog2(NUM_WIRES),
  localparam int GAW       = $clog2(NUM_GATES),
  localparam int CW        = 2 + 3*WAW,
  localparam int NGW       = $clog2(NUM_GATES+1)
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [GAW-1:0]     cfg_addr,
  input  logic [CW-1:0]      cfg_data,
  input  logic [NGW-1:0]     num_gates,
  input  logic [NUM_IN-1:0]  in_vec,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [NUM_OUT-1:0] out_vec
);

  state_e               state;
  gate_t                gate_tab [NUM_GATES];
  logic [NUM_WIRES-1:0] wires;
  logic [NUM_WIRES-1:0] wire_next;
  logic [NGW-1:0]       ng;
  logic [NGW-1:0]       pc;
  gate_t                cur;
  logic                 alu_a;
  logic                 alu_b;
  logic                 alu_y;

  gate_alu u_alu (
    .op (cur.op),
    .a  (alu_a),
    .b  (alu_b),
    .y  (alu_y)
  );

  // Next wire contents; out_vec samples this so the last gate's write is visible.
  always_comb begin
    cur       = gate_tab[pc[GAW-1:0]];
    alu_a     = wires[cur.src_a];
    alu_b     = wires[cur.src_b];
    wire_next = wires;
    case (state)
      ST_LOAD: wire_next = NUM_WIRES'(in_vec);
      ST_EVAL: wire_next[cur.dst] = alu_y;
      default: ;
    endcase
  end

  // NOTE: the table is real state a run depends on, so it is cleared by reset like any other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_GATES; i++) gate_tab[i] <= '0;
    end else if (cfg_we && state == ST_IDLE && 32'(cfg_addr) < NUM_GATES) begin
      gate_tab[cfg_addr] <= gate_t'(cfg_data);
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      wires   <= '0;
      ng      <= '0;
      pc      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      out_vec <= '0;
    end else begin
      wires <= wire_next;
      done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            ng    <= (num_gates > NGW'(NUM_GATES)) ? NGW'(NUM_GATES) : num_gates;
            pc    <= '0;
            busy  <= 1'b1;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (ng != '0) begin
            state <= ST_EVAL;
          end else begin
            state   <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            out_vec <= wire_next[NUM_WIRES-1 -: NUM_OUT];
          end
        end
        ST_EVAL: begin
          if (pc == ng - 1'b1) begin
            state   <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            out_vec <= wire_next[NUM_WIRES-1 -: NUM_OUT];
          end else begin
            pc <= pc + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_eval_scheduler.sv
// Scoreboard bench for gate_eval_scheduler: each run pushes its expected
// out_vec and start-to-done latency; a monitor pops and compares on done.
module tb_gate_eval_scheduler;
  import gate_eval_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [13:0] cfg_data = '0;
  logic [3:0]  num_gates = '0;
  logic [1:0]  in_vec = '0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [1:0]  out_vec;

  gate_eval_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .num_gates (num_gates),
    .in_vec    (in_vec),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .out_vec   (out_vec)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] out;
    int         lat;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   since_start = 0;
  int   done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: negedge k after the start cycle sees since_start == k.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "_out"}, 32'(out_vec), 32'(e.out));
        check({e.tag, "_lat"}, since_start, e.lat);
      end
    end
    since_start++;
  end

  function automatic logic [13:0] enc(input op_e op, input logic [3:0] a, input logic [3:0] b,
                                      input logic [3:0] d);
    return {op, a, b, d};
  endfunction

  // All tasks enter and leave 1 time unit after a rising edge.
  task automatic cfg(input logic [2:0] addr, input op_e op, input logic [3:0] a,
                     input logic [3:0] b, input logic [3:0] d);
    cfg_we = 1'b1; cfg_addr = addr; cfg_data = enc(op, a, b, d);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic push_exp(input logic [3:0] ng, input logic [1:0] exp_out, input string tag);
    exp_t e;
    e.out = exp_out;
    e.lat = ((ng > 4'd8) ? 8 : int'(ng)) + 2;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      check("done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic do_run(input logic [3:0] ng, input logic [1:0] inv, input logic [1:0] exp_out,
                        input string tag);
    push_exp(ng, exp_out, tag);
    num_gates = ng; in_vec = inv; start = 1'b1; since_start = 0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain(30);
  endtask

  initial begin
    int dc0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out", 32'(out_vec), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Two-gate netlist: w15 = w0|w1, w14 = w0&w1; out_vec = {w15, w14}.
    cfg(3'd0, OP_OR,  4'd0, 4'd1, 4'd15);
    cfg(3'd1, OP_AND, 4'd0, 4'd1, 4'd14);
    do_run(4'd2, 2'b01, 2'b10, "two_gate_01");
    do_run(4'd2, 2'b11, 2'b11, "two_gate_11");
    do_run(4'd2, 2'b00, 2'b00, "two_gate_00");

    // Chain: w2 = w0^w1, w15 = ~w2, w14 = w2&w0.
    cfg(3'd0, OP_XOR, 4'd0, 4'd1, 4'd2);
    cfg(3'd1, OP_NOT, 4'd2, 4'd0, 4'd15);
    cfg(3'd2, OP_AND, 4'd2, 4'd0, 4'd14);
    do_run(4'd3, 2'b10, 2'b00, "chain_w1");
    do_run(4'd3, 2'b01, 2'b01, "chain_w0");

    // Empty run and clamped run (entries 3..7 are AND w0,w0->w0, harmless).
    do_run(4'd0, 2'b11, 2'b00, "ng_zero");
    do_run(4'd15, 2'b01, 2'b01, "ng_clamp");

    // Busy protection: start and cfg_we during EVAL must be ignored.
    cfg(3'd0, OP_OR,  4'd0, 4'd1, 4'd15);
    cfg(3'd1, OP_AND, 4'd0, 4'd1, 4'd14);
    dc0 = done_cnt;
    push_exp(4'd2, 2'b10, "busy_run");
    num_gates = 4'd2; in_vec = 2'b01; start = 1'b1; since_start = 0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("busy_in_eval", 32'(busy), 32'd1);
    start = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = enc(OP_AND, 4'd0, 4'd1, 4'd15);
    @(posedge clk); #1;
    start = 1'b0; cfg_we = 1'b0;
    wait_drain(30);
    repeat (6) @(posedge clk);
    #1;
    check("busy_one_done", 32'(done_cnt - dc0), 32'd1);
    check("idle_not_busy", 32'(busy), 32'd0);
    do_run(4'd2, 2'b01, 2'b10, "busy_table_kept");

    // Reset mid-EVAL: outputs clear at once; the table is cleared too.
    num_gates = 4'd3; in_vec = 2'b11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_out", 32'(out_vec), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_run(4'd1, 2'b11, 2'b00, "post_reset_empty");

    // Dst overwrite: w0 = ~w0, then w15 = w0|w0.
    cfg(3'd0, OP_NOT, 4'd0, 4'd0, 4'd0);
    cfg(3'd1, OP_OR,  4'd0, 4'd0, 4'd15);
    do_run(4'd2, 2'b01, 2'b00, "overwrite_01");
    do_run(4'd2, 2'b00, 2'b10, "overwrite_00");

    // cfg_we together with start: the run must use the new entry1 = NOT w1 -> w15.
    push_exp(4'd2, 2'b10, "cfg_with_start");
    cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = enc(OP_NOT, 4'd1, 4'd0, 4'd15);
    num_gates = 4'd2; in_vec = 2'b01; start = 1'b1; since_start = 0;
    @(posedge clk); #1;
    cfg_we = 1'b0; start = 1'b0;
    wait_drain(30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
